// File: rtl/valid_ready_bus_system.sv
// Valid/ready streaming chain: counting master -> two-entry skid-buffer bus slice -> counting slave.
// Optional build macro SEQ_CHECK_EN adds the slave's sticky sequence-mismatch check on rx_error.
module valid_ready_bus_system #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              master_en,
    input  logic              receive_en,
    output logic              master_valid,
    output logic [DATA_W-1:0] master_data,
    output logic              bus_ready,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              slave_ready,
    output logic [CNT_W-1:0]  rx_count,
    output logic [DATA_W-1:0] rx_last_data,
    output logic              rx_error
);

    logic              mvalid_q, mvalid_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [DATA_W-1:0] next_q, next_d;
    logic              bvalid_q, bvalid_d;
    logic [DATA_W-1:0] bdata_q, bdata_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              bready_q, bready_d;
    logic              sready_q, sready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              m_hs, s_hs;

    assign m_hs = mvalid_q && bready_q;
    assign s_hs = bvalid_q && sready_q;

    // Master: a valid word is held until accepted; a new word is loaded whenever enabled and free.
    always_comb begin
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        next_d   = next_q;
        if (master_en && (!mvalid_q || m_hs)) begin
            mvalid_d = 1'b1;
            mdata_d  = next_q;
            next_d   = next_q + DATA_W'(1);
        end else if (m_hs) begin
            mvalid_d = 1'b0;
        end
    end

    // Bus slice: output register first, skid catches the word accepted while the output stalls.
    always_comb begin
        bvalid_d     = bvalid_q;
        bdata_d      = bdata_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (s_hs) begin
            if (skid_valid_q) begin
                bdata_d      = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                bvalid_d = 1'b0;
            end
        end
        if (m_hs) begin
            if (!bvalid_q || (s_hs && !skid_valid_q)) begin
                bvalid_d = 1'b1;
                bdata_d  = mdata_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = mdata_q;
            end
        end
        bready_d = !skid_valid_d;
    end

    // Slave: ready follows receive_en one cycle late; count and remember accepted words.
    always_comb begin
        sready_d = receive_en;
        cnt_d    = cnt_q;
        last_d   = last_q;
        if (s_hs) begin
            cnt_d  = cnt_q + CNT_W'(1);
            last_d = bdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (RSTn) begin
            mvalid_q     <= 1'b0;
            mdata_q      <= '0;
            next_q       <= '0;
            bvalid_q     <= 1'b0;
            bdata_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            bready_q     <= 1'b0;
            sready_q     <= 1'b0;
            cnt_q        <= '0;
            last_q       <= '0;
        end else begin
            mvalid_q     <= mvalid_d;
            mdata_q      <= mdata_d;
            next_q       <= next_d;
            bvalid_q     <= bvalid_d;
            bdata_q      <= bdata_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            bready_q     <= bready_d;
            sready_q     <= sready_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
        end
    end

`ifdef SEQ_CHECK_EN
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              err_q, err_d;

    // Sequence check resynchronises on the received word so one glitch flags once.
    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (s_hs) begin
            if (bdata_q != exp_q) err_d = 1'b1;
            exp_d = bdata_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (RSTn) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign rx_error = err_q;
`else
    assign rx_error = 1'b0;
`endif

    assign master_valid = mvalid_q;
    assign master_data  = mdata_q;
    assign bus_ready    = bready_q;
    assign bus_valid    = bvalid_q;
    assign bus_data     = bdata_q;
    assign slave_ready  = sready_q;
    assign rx_count     = cnt_q;
    assign rx_last_data = last_q;

endmodule

// File: tb/tb_valid_ready_bus_system.sv
// Scoreboarded random/directed bench for valid_ready_bus_system: words the master hands off are
// queued, and the monitor pops them as the slave accepts, alongside occupancy-based flow checks.
module tb_valid_ready_bus_system;

    logic        clk = 1'b0;
    logic        RSTn;
    logic        master_en;
    logic        receive_en;
    logic        master_valid;
    logic [23:0] master_data;
    logic        bus_ready;
    logic        bus_valid;
    logic [23:0] bus_data;
    logic        slave_ready;
    logic [15:0] rx_count;
    logic [23:0] rx_last_data;
    logic        rx_error;

    int unsigned errors = 0;
    int unsigned checks = 0;

    valid_ready_bus_system dut (
        .clk          (clk),
        .RSTn         (RSTn),
        .master_en    (master_en),
        .receive_en   (receive_en),
        .master_valid (master_valid),
        .master_data  (master_data),
        .bus_ready    (bus_ready),
        .bus_valid    (bus_valid),
        .bus_data     (bus_data),
        .slave_ready  (slave_ready),
        .rx_count     (rx_count),
        .rx_last_data (rx_last_data),
        .rx_error     (rx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words in flight inside the bus, in order, plus the stream/acceptance counters.
    logic [23:0] sb_q[$];
    logic [23:0] gen      = '0;
    logic [15:0] acc      = '0;
    logic [23:0] last_acc = '0;
    int          occ      = 0;
    bit          prev_rst = 1'b1;
    bit          p_mv = 1'b0, p_hs = 1'b0, p_en = 1'b0, p_ren = 1'b0;
    logic [23:0] p_md = '0;

    // Monitor: outputs are stable at the falling edge and show what the next rising edge will do.
    always @(negedge clk) begin
        bit hs_m, hs_s;
        if (RSTn) begin
            sb_q.delete();
            gen = '0; acc = '0; last_acc = '0; occ = 0;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("rst_master_valid", 32'(master_valid), 32'd0);
                chk("rst_master_data",  32'(master_data),  32'd0);
                chk("rst_bus_ready",    32'(bus_ready),    32'd0);
                chk("rst_bus_valid",    32'(bus_valid),    32'd0);
                chk("rst_bus_data",     32'(bus_data),     32'd0);
                chk("rst_slave_ready",  32'(slave_ready),  32'd0);
                chk("rst_rx_count",     32'(rx_count),     32'd0);
                chk("rst_rx_last",      32'(rx_last_data), 32'd0);
                chk("rst_rx_error",     32'(rx_error),     32'd0);
            end else begin
                chk("master_valid", 32'(master_valid), 32'((p_mv && !p_hs) || p_en));
                if (p_mv && !p_hs) chk("master_hold_data", 32'(master_data), 32'(p_md));
                chk("slave_ready",  32'(slave_ready), 32'(p_ren));
                chk("bus_ready",    32'(bus_ready),   32'(occ < 2));
                chk("bus_valid",    32'(bus_valid),   32'(occ > 0));
                chk("rx_count",     32'(rx_count),    32'(acc));
                chk("rx_last_data", 32'(rx_last_data), 32'(last_acc));
                chk("rx_error",     32'(rx_error),    32'd0);
            end
            hs_s = bus_valid && slave_ready;
            hs_m = master_valid && bus_ready;
            if (hs_s) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(bus_data), 32'hFFFF_FFFF);
                end else begin
                    chk("bus_data_order", 32'(bus_data), 32'(sb_q.pop_front()));
                end
                acc      = acc + 16'd1;
                last_acc = bus_data;
                occ--;
            end
            if (hs_m) begin
                chk("master_data_seq", 32'(master_data), 32'(gen));
                sb_q.push_back(gen);
                gen = gen + 24'd1;
                occ++;
            end
            p_mv = master_valid; p_md = master_data; p_hs = hs_m;
            prev_rst = 1'b0;
        end
        p_en  = master_en;
        p_ren = receive_en;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit me, input bit re, input int n);
        master_en  = me;
        receive_en = re;
        step(n);
    endtask

    initial begin
        int bound;
        RSTn = 1'b1; master_en = 1'b0; receive_en = 1'b0;
        step(2);
        RSTn = 1'b0;
        drive(0, 0, 4);
        drive(1, 1, 10);
        drive(1, 0, 5);
        drive(1, 1, 6);
        drive(1, 0, 3);
        drive(0, 0, 3);
        drive(0, 1, 5);
        for (int r = 0; r < 3; r++) begin
            drive(1, 1, 1); drive(1, 0, 1); drive(1, 1, 2); drive(1, 0, 1);
        end
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1);
        drive(1, 1, 9);
        RSTn = 1'b1;
        step(1);
        RSTn = 1'b0;
        drive(1, 1, 8);
        drive(1, 0, 4);
        drive(0, 1, 1);
        bound = 0;
        while ((sb_q.size() != 0 || bus_valid || master_valid) && bound < 50) begin
            step(1);
            bound++;
        end
        chk("drain_timeout", 32'(bound < 50), 32'd1);
        @(negedge clk);
        chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("final_rx_count", 32'(rx_count), 32'(gen[15:0]));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
